// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response, redirect input,
// and the instruction stream handed to decode.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer happens
// on a rising clock edge where valid and ready are both 1. A valid source holds
// its payload stable until that edge. The imem response channel has no ready;
// the fetch queue reserves a slot before issuing each request, so it can always
// accept a response.
interface instr_fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues in-order word reads with a
// credit limit of DEPTH, buffers returned words with their PCs and hands them to
// decode. A redirect flushes the queue; responses still in flight from before
// the redirect are counted and dropped in the FLUSH state.
// Optional build macro IFQ_BYPASS_EN: a response arriving while the queue is
// empty is presented to decode in the same cycle (0-cycle latency).
// dbg_flush exposes the FSM state (1 = FLUSH).
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    instr_fetch_queue_if.master        bus,
    output logic                       dbg_flush
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  stale_q, stale_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic           req_en_q, req_en_d;
    logic           instr_valid_q, instr_valid_d;
    logic [31:0]    instr_q, instr_d, instr_pc_q, instr_pc_d;

    logic [31:0]    data_mem [DEPTH];
    logic [31:0]    pc_mem   [DEPTH];
    logic [31:0]    tag_mem  [DEPTH];

    logic           req_fire, resp_live, push, pop, bypass_hit;
    logic [31:0]    resp_pc;
    logic [CW:0]    occupancy;

    // Next-state computation for the FSM, counters, pointers and output head
    always_comb begin
        req_fire  = bus.imem_req_valid && bus.imem_req_ready;
        // A response only counts in FETCH and only if a request is outstanding;
        // anything else is a stale drop or a protocol error.
        resp_live = bus.imem_resp_valid && (state_q == FETCH) && (inflight_q != '0);
        resp_pc   = tag_mem[tag_rd_q];
`ifdef IFQ_BYPASS_EN
        bypass_hit = resp_live && (count_q == '0) && !bus.redirect_valid;
`else
        bypass_hit = 1'b0;
`endif
        pop  = instr_valid_q && bus.instr_ready && !bus.redirect_valid;
        push = resp_live && !bus.redirect_valid && !(bypass_hit && bus.instr_ready);

        state_d    = state_q;
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_live);
        tag_wr_d   = tag_wr_q + AW'(req_fire);
        tag_rd_d   = tag_rd_q + AW'(resp_live);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        stale_d    = stale_q;

        // Drain pre-redirect responses; fetch resumes once the last one is gone
        if (state_q == FLUSH && bus.imem_resp_valid && stale_q != '0) begin
            stale_d = stale_q - CW'(1);
            if (stale_q == CW'(1)) begin
                state_d = FETCH;
            end
        end

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~32'd3;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            tag_rd_d   = tag_wr_q;
            if (state_q == FETCH) begin
                // A response landing in this cycle is already retired
                stale_d    = inflight_q - CW'(resp_live);
                inflight_d = '0;
                state_d    = (stale_d != '0) ? FLUSH : FETCH;
            end
        end

        // Registered head: hold when the queue goes empty, otherwise track the oldest entry
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (!bus.redirect_valid) begin
            if (pop) begin
                if (count_q > CW'(1)) begin
                    instr_d    = data_mem[rd_ptr_q + AW'(1)];
                    instr_pc_d = pc_mem[rd_ptr_q + AW'(1)];
                end else if (push) begin
                    instr_d    = bus.imem_resp_data;
                    instr_pc_d = resp_pc;
                end
            end else if (count_q == '0 && push) begin
                instr_d    = bus.imem_resp_data;
                instr_pc_d = resp_pc;
            end
        end

        instr_valid_d = (count_d != '0);
        occupancy     = {1'b0, count_d} + {1'b0, inflight_d};
        req_en_d      = (state_d == FETCH) && (occupancy < (CW+1)'(DEPTH));
    end

    // Entry storage for the data queue and the request-address tag queue
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.imem_resp_data;
            pc_mem[wr_ptr_q]   <= resp_pc;
        end
        if (req_fire) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
    end

    // State, counters, pointers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            inflight_q    <= '0;
            stale_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            req_en_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            stale_q       <= stale_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            req_en_q      <= req_en_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // A redirect pulse suppresses the request issued in the same cycle
    assign bus.imem_req_valid = req_en_q && !bus.redirect_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
`ifdef IFQ_BYPASS_EN
    assign bus.instr_valid = instr_valid_q || bypass_hit;
    assign bus.instr       = bypass_hit ? bus.imem_resp_data : instr_q;
    assign bus.instr_pc    = bypass_hit ? resp_pc : instr_pc_q;
`else
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
`endif
    assign dbg_flush = (state_q == FLUSH);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: random memory latency, decode stalls and
// redirects. The reference model is the program-order stream: after reset or a
// redirect, requests and delivered instructions walk consecutive word
// addresses from the new PC, and (accepted - consumed) in the current stream
// never exceeds DEPTH.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_flush;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_flush(dbg_flush)
  );

  // ---------------- shared state ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_pct = 0, req_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1;
  bit force_redir = 1'b0;
  logic [31:0] force_pc = '0;

  logic [63:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int pend_due[$];
  int pend_seg[$];
  int cur_seg = 0;
  logic [31:0] exp_req_addr = '0;
  logic [31:0] gen_pc = '0;
  int cnt = 0, seg_acc = 0, seg_cons = 0, accepts = 0, consumed = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0050_0093;
  endfunction

  task automatic refill();
    while (exp_q.size() < 64) begin
      exp_q.push_back({gen_pc, word_of(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_model(input logic [31:0] pc);
    cur_seg++;
    exp_req_addr = pc;
    gen_pc = pc;
    exp_q.delete();
    refill();
    cnt = 0;
    seg_acc = 0;
    seg_cons = 0;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFF8;
      2: return $urandom();
      default: return 32'h0000_0200 + 32'($urandom_range(0, 64));
    endcase
  endfunction

  // ---------------- driver: memory, decode, branch unit ----------------
  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.imem_req_ready = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b0;
      end else begin
        if (force_redir) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc = force_pc;
          force_redir = 1'b0;
        end else if ($urandom_range(0, 99) < redir_pct) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc = pick_target();
        end else begin
          bus.redirect_valid = 1'b0;
          bus.redirect_pc = $urandom();
        end
        bus.instr_ready = ($urandom_range(0, 99) < rdy_pct);
        bus.imem_req_ready = ($urandom_range(0, 99) < req_pct);
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data = word_of(pend_addr[0]);
        end else begin
          bus.imem_resp_valid = 1'b0;
          bus.imem_resp_data = $urandom();
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit resp_now, resp_cur, ev, pop, stale_pending;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        cyc++;
        resp_now = bus.imem_resp_valid;
        resp_cur = resp_now && pend_seg.size() > 0 && pend_seg[0] == cur_seg;
        ev = (cnt > 0) || (BYP && resp_cur && cnt == 0 && !bus.redirect_valid);
        chk("instr_valid", {63'd0, bus.instr_valid}, {63'd0, ev});
        if (bus.redirect_valid)
          chk("req_during_redirect", {63'd0, bus.imem_req_valid}, 64'd0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          chk("req_addr", {32'd0, bus.imem_req_addr}, {32'd0, exp_req_addr});
          chk("credit", {63'd0, (seg_acc - seg_cons) < DEPTH}, 64'd1);
          stale_pending = 1'b0;
          foreach (pend_seg[i]) if (pend_seg[i] != cur_seg) stale_pending = 1'b1;
          chk("req_while_stale", {63'd0, stale_pending}, 64'd0);
          pend_addr.push_back(bus.imem_req_addr);
          pend_due.push_back(cyc + $urandom_range(lat_min, lat_max));
          pend_seg.push_back(cur_seg);
          exp_req_addr = exp_req_addr + 32'd4;
          seg_acc++;
          accepts++;
        end
        pop = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
        if (pop) begin
          if (exp_q.size() == 0) begin
            chk("exp_underflow", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("instr_out", {bus.instr_pc, bus.instr}, e);
          end
          consumed++;
          seg_cons++;
        end
        if (bus.redirect_valid) cnt = 0;
        else cnt = cnt + int'(resp_cur) - int'(pop);
        if (resp_now && pend_addr.size() > 0) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
          void'(pend_seg.pop_front());
        end
        if (bus.redirect_valid) restart_model(bus.redirect_pc & ~32'd3);
        else if (exp_q.size() < 16) refill();
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    int guard;
    // Reset state
    #8;
    chk("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("rst_req_addr", {32'd0, bus.imem_req_addr}, 64'd0);
    chk("rst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
    chk("rst_instr", {32'd0, bus.instr}, 64'd0);
    chk("rst_instr_pc", {32'd0, bus.instr_pc}, 64'd0);
    restart_model(32'h0);
    rdy_pct = 0; req_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
    accepts = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Decode stalled: exactly DEPTH requests, then requests stop
    repeat (12) @(negedge clk);
    #4;
    chk("stall_accepts", 64'(accepts), 64'(DEPTH));
    chk("stall_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);

    // Release: in-order drain, then full-rate streaming
    rdy_pct = 100;
    repeat (10) @(negedge clk);
    #4;
    c0 = consumed;
    repeat (20) @(negedge clk);
    #4;
    chk("stream_rate", 64'(consumed - c0), 64'd20);

    // Reset in the middle of FLUSH with several requests in flight
    rdy_pct = 0; lat_min = 5; lat_max = 5;
    force_pc = 32'h0000_0040; force_redir = 1'b1;
    @(negedge clk);
    #4;
    guard = 0;
    while (seg_acc < 3 && guard < 40) begin
      @(negedge clk);
      #4;
      guard++;
    end
    chk("t5_fill", {63'd0, seg_acc >= 3}, 64'd1);
    force_pc = 32'h0000_0080; force_redir = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t5_in_flush", {63'd0, dbg_flush}, 64'd1);
    reset = 1'b1;
    pend_addr.delete(); pend_due.delete(); pend_seg.delete();
    #1;
    chk("t5_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("t5_req_addr", {32'd0, bus.imem_req_addr}, 64'd0);
    chk("t5_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
    chk("t5_instr", {32'd0, bus.instr}, 64'd0);
    chk("t5_instr_pc", {32'd0, bus.instr_pc}, 64'd0);
    chk("t5_state", {63'd0, dbg_flush}, 64'd0);
    restart_model(32'h0);
    rdy_pct = 70; req_pct = 70; lat_min = 1; lat_max = 4; redir_pct = 3;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Random traffic with redirects (incl. 0x103 and wrap targets)
    repeat (2500) @(negedge clk);
    rdy_pct = 25; req_pct = 90; lat_min = 1; lat_max = 6; redir_pct = 2;
    repeat (1500) @(negedge clk);
    rdy_pct = 100; req_pct = 100; lat_min = 1; lat_max = 2; redir_pct = 0;
    repeat (60) @(negedge clk);
    #4;
    chk("progress", {63'd0, consumed > 200}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
